i2c_slave_responder: RTL and testbench

Synthesizable I2C target (slave) that answers the I2CMB master on one bus, the responding end of the protocol the I2CMB drives. It samples raw SCL/SDA, detects START/STOP and repeated START, matches a 7-bit address, and ACKs it. Write bytes go out on a strobe interface and read bytes come in on a request/response handshake. It serves as a DUT-side responder in multi-bus benches and as a reusable target for FPGA bring-up.

---
 rtl/i2c_slave_pkg.sv | 20 ++
 rtl/i2c_line_sync.sv | 41 ++++
 rtl/i2c_slave_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared widths, the read idle byte and the responder state type.
package i2c_slave_pkg;

  localparam int unsigned I2C_ADDR_W       = 7;
  localparam int unsigned I2C_BYTE_W       = 8;
  localparam logic [7:0]  I2C_RD_IDLE_BYTE = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_WR_BYTE  = 4'd3,
    ST_WR_ACK   = 4'd4,
    ST_RD_FETCH = 4'd5,
    ST_RD_BYTE  = 4'd6,
    ST_RD_ACK   = 4'd7,
    ST_IGNORE   = 4'd8
  } i2c_slave_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes raw SCL/SDA and derives SCL edge and START/STOP pulses.
// The synchronizer chain is deliberately not reset so that a mid-transfer reset
// cannot fabricate a bus condition when the chain would refill.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_ff;
  logic [SYNC_STAGES-1:0] sda_ff;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_ff[SYNC_STAGES-1];
  assign sda_s = sda_ff[SYNC_STAGES-1];

  // Synchronizer chains plus one history stage for edge detection.
  always_ff @(posedge clk_i) begin
    scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_i};
    sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
    scl_d  <= scl_s;
    sda_d  <= sda_s;
  end

  assign sda      = sda_s;
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target with 7-bit address match, write strobe and
// read request/response interface.
// Build option: define I2C_SLAVE_CLK_STRETCH_EN to hold SCL low while read data is late.
module i2c_slave_responder
  import i2c_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned STRETCH_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [I2C_ADDR_W-1:0] slave_addr_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_oe_o,
  output logic                  sda_oe_o,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  busy_o,
  output logic                  dir_o,
  output logic                  wr_valid_o,
  output logic [I2C_BYTE_W-1:0] wr_data_o,
  output logic                  rd_req_o,
  input  logic                  rd_valid_i,
  input  logic [I2C_BYTE_W-1:0] rd_data_i
);

  if (SYNC_STAGES < 2 || STRETCH_TIMEOUT < 1) begin : g_param_check
    $error("i2c_slave_responder: SYNC_STAGES must be >= 2 and STRETCH_TIMEOUT >= 1");
  end

  i2c_slave_state_t      state;
  logic [I2C_ADDR_W-1:0] addr_q;
  logic [I2C_BYTE_W-1:0] shift_q;
  logic [2:0]            bit_cnt;
  logic                  phase;    // ACK states: ACK driven; RD_FETCH: request issued
  logic                  pending;  // read request outstanding

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i    (clk_i),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_det),
    .stop     (stop_det)
  );

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  localparam int unsigned TMO_W = $clog2(STRETCH_TIMEOUT + 1);
  logic [TMO_W-1:0] stretch_cnt;
`else
  assign scl_oe_o = 1'b0;
`endif

  // Protocol FSM: bus conditions first, then per-state bit handling.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      shift_q    <= '0;
      bit_cnt    <= '0;
      phase      <= 1'b0;
      pending    <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy_o     <= 1'b0;
      dir_o      <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_data_o  <= '0;
      rd_req_o   <= 1'b0;
      sda_oe_o   <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_oe_o    <= 1'b0;
      stretch_cnt <= '0;
`endif
    end else begin
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      wr_valid_o <= 1'b0;
      rd_req_o   <= 1'b0;
      if (start_det) begin
        start_o  <= 1'b1;
        state    <= ST_ADDR;
        addr_q   <= slave_addr_i;
        bit_cnt  <= '0;
        phase    <= 1'b0;
        pending  <= 1'b0;
        busy_o   <= 1'b0;
        sda_oe_o <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        scl_oe_o <= 1'b0;
`endif
      end else if (stop_det) begin
        stop_o   <= 1'b1;
        state    <= ST_IDLE;
        pending  <= 1'b0;
        busy_o   <= 1'b0;
        sda_oe_o <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        scl_oe_o <= 1'b0;
`endif
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shift_q <= {shift_q[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shift_q[6:0] == addr_q) begin
                dir_o  <= sda_s;
                busy_o <= 1'b1;
                phase  <= 1'b0;
                state  <= ST_ADDR_ACK;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
            if (!phase) begin
              sda_oe_o <= 1'b1;
              phase    <= 1'b1;
            end else begin
              sda_oe_o <= 1'b0;
              phase    <= 1'b0;
              bit_cnt  <= '0;
              if (state == ST_ADDR_ACK && dir_o) begin
                state <= ST_RD_FETCH;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                scl_oe_o    <= 1'b1;
                stretch_cnt <= '0;
`endif
              end else begin
                state <= ST_WR_BYTE;
              end
            end
          end
          ST_WR_BYTE: if (scl_rise) begin
            shift_q <= {shift_q[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              wr_valid_o <= 1'b1;
              wr_data_o  <= {shift_q[6:0], sda_s};
              phase      <= 1'b0;
              state      <= ST_WR_ACK;
            end
          end
          ST_RD_FETCH: begin
            if (!phase) begin
              phase <= 1'b1;
              if (!pending) begin
                rd_req_o <= 1'b1;
                pending  <= 1'b1;
              end
            end else if (pending && rd_valid_i) begin
              // SCL stays held here; RD_BYTE releases it one cycle after SDA settles.
              shift_q  <= rd_data_i;
              sda_oe_o <= ~rd_data_i[7];
              pending  <= 1'b0;
              bit_cnt  <= '0;
              state    <= ST_RD_BYTE;
            end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            else if (stretch_cnt == TMO_W'(STRETCH_TIMEOUT - 1)) begin
              scl_oe_o <= 1'b0;
              shift_q  <= I2C_RD_IDLE_BYTE;
              sda_oe_o <= 1'b0;
              bit_cnt  <= '0;
              state    <= ST_RD_BYTE;
            end else begin
              stretch_cnt <= stretch_cnt + TMO_W'(1);
            end
`else
            else if (scl_rise) begin
              // The master already sampled the released MSB; finish the idle byte.
              shift_q  <= I2C_RD_IDLE_BYTE;
              sda_oe_o <= 1'b0;
              pending  <= 1'b0;
              bit_cnt  <= '0;
              state    <= ST_RD_BYTE;
            end
`endif
          end
          ST_RD_BYTE: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_oe_o <= 1'b0;
`endif
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe_o <= 1'b0;
                phase    <= 1'b0;
                state    <= ST_RD_ACK;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b1};
                sda_oe_o <= ~shift_q[6];
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise && !phase) begin
              if (sda_s) begin
                busy_o <= 1'b0;
                state  <= ST_IGNORE;
              end else begin
                phase <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              phase <= 1'b0;
              state <= ST_RD_FETCH;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
              scl_oe_o    <= 1'b1;
              stretch_cnt <= '0;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bit-level I2C master, read-data responder and
// transaction-level expectations for i2c_slave_responder.
module tb_i2c_slave_responder;

  localparam int H = 20;  // SCL high time in clocks
  localparam int Q = 10;  // SCL low time is 2*Q
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] slave_addr = 7'h22;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_line, sda_line;
  logic       scl_oe, sda_oe, start_o, stop_o, busy_o, dir_o, wr_valid_o, rd_req_o;
  logic [7:0] wr_data_o;
  logic       rd_valid_i = 1'b0;
  logic [7:0] rd_data_i = 8'h00;

  always #5 clk = ~clk;

  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_responder #(.SYNC_STAGES(2), .STRETCH_TIMEOUT(1024)) dut (
    .clk_i(clk), .rst_i(rst_i), .slave_addr_i(slave_addr),
    .scl_i(scl_line), .sda_i(sda_line), .scl_oe_o(scl_oe), .sda_oe_o(sda_oe),
    .start_o(start_o), .stop_o(stop_o), .busy_o(busy_o), .dir_o(dir_o),
    .wr_valid_o(wr_valid_o), .wr_data_o(wr_data_o), .rd_req_o(rd_req_o),
    .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i)
  );

  int checks = 0, failures = 0;
  int n_start = 0, n_stop = 0, n_req = 0, n_sda_oe = 0, n_scl_oe = 0, n_busy = 0;
  logic [7:0] wr_q[$];
  logic [7:0] tx_bytes[$];
  logic [7:0] rd_bytes[$];
  int rd_delay = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (start_o)    n_start++;
    if (stop_o)     n_stop++;
    if (rd_req_o)   n_req++;
    if (sda_oe)     n_sda_oe++;
    if (scl_oe)     n_scl_oe++;
    if (busy_o)     n_busy++;
    if (wr_valid_o) wr_q.push_back(wr_data_o);
  end

  // Read-data responder: answers each request after rd_delay clocks.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_req_o) begin
        repeat (rd_delay) @(negedge clk);
        rd_data_i  = (rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'h00;
        rd_valid_i = 1'b1;
        @(negedge clk);
        rd_valid_i = 1'b0;
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_release();
    int w = 0;
    scl_m = 1'b1;
    tick(1);
    while (scl_line == 1'b0 && w < 3000) begin
      tick(1);
      w++;
    end
    check_eq("scl_release", scl_line, 1'b1);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(Q); scl_release(); tick(H); scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q); scl_release(); tick(H/2); b = sda_line; tick(H/2);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; tick(H); scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; tick(Q); scl_release(); tick(H/2); sda_m = 1'b0; tick(H/2);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q); scl_release(); tick(H/2); sda_m = 1'b1; tick(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) get_bit(b[i]);
    put_bit(nack);
  endtask

  // One addressed transaction; expectations follow from whether the address hits.
  task automatic run_txn(input string nm, input logic [6:0] a, input logic rd, input int n,
                         input bit rstart, input bit end_stop, input bit late);
    int s_start, s_stop, s_req, s_sda, s_busy, s_scl;
    logic ack;
    logic [7:0] b;
    logic [7:0] exp_rd[$];
    bit hit;
    hit = (a == slave_addr);
    exp_rd = rd_bytes;
    s_start = n_start; s_stop = n_stop; s_req = n_req;
    s_sda = n_sda_oe; s_busy = n_busy; s_scl = n_scl_oe;
    wr_q.delete();
    if (rstart) i2c_rstart(); else i2c_start();
    check_eq({nm, "/start_pulse"}, n_start - s_start, 1);
    write_byte({a, rd}, ack);
    check_eq({nm, "/addr_ack"}, ack, !hit);
    check_eq({nm, "/busy"}, busy_o, hit);
    if (hit) check_eq({nm, "/dir"}, dir_o, rd);
    if (!rd) begin
      for (int i = 0; i < n; i++) begin
        write_byte(tx_bytes[i], ack);
        check_eq({nm, "/data_ack"}, ack, !hit);
      end
      check_eq({nm, "/wr_count"}, wr_q.size(), hit ? n : 0);
      for (int i = 0; i < n && i < wr_q.size(); i++)
        check_eq({nm, "/wr_data"}, wr_q[i], tx_bytes[i]);
    end else if (hit) begin
      for (int i = 0; i < n; i++) begin
        read_byte(b, i == n - 1);
        check_eq({nm, "/rd_data"}, b, (late && !STRETCH) ? 8'hFF : exp_rd[i]);
      end
      check_eq({nm, "/rd_req_count"}, n_req - s_req, n);
      if (late)
        check_eq({nm, "/stretch_window"}, (n_scl_oe - s_scl) >= 450 && (n_scl_oe - s_scl) <= 650,
                 STRETCH);
    end
    if (!hit) begin
      check_eq({nm, "/no_sda_drive"}, n_sda_oe - s_sda, 0);
      check_eq({nm, "/no_busy"}, n_busy - s_busy, 0);
      check_eq({nm, "/no_req"}, n_req - s_req, 0);
    end
    if (end_stop) begin
      i2c_stop();
      check_eq({nm, "/stop_pulse"}, n_stop - s_stop, 1);
      check_eq({nm, "/busy_end"}, busy_o, 1'b0);
    end
    rd_bytes.delete();
    tx_bytes.delete();
  endtask

  initial begin
    logic ack;
    logic [7:0] b;
    int s_start;
    tick(5);
    check_eq("rst/sda_oe", sda_oe, 0);
    check_eq("rst/scl_oe", scl_oe, 0);
    check_eq("rst/start", start_o, 0);
    check_eq("rst/stop", stop_o, 0);
    check_eq("rst/busy", busy_o, 0);
    check_eq("rst/dir", dir_o, 0);
    check_eq("rst/wr_valid", wr_valid_o, 0);
    check_eq("rst/wr_data", wr_data_o, 0);
    check_eq("rst/rd_req", rd_req_o, 0);
    rst_i = 1'b0;
    tick(10);

    // Plain write.
    tx_bytes = '{8'hA5, 8'h3C};
    run_txn("write", 7'h22, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    tick(20);
    // Foreign address.
    tx_bytes = '{8'h11, 8'h00};
    run_txn("foreign", 7'h50, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    tick(20);
    // Two-byte read.
    rd_bytes = '{8'h81, 8'h7E};
    run_txn("read", 7'h22, 1'b1, 2, 1'b0, 1'b1, 1'b0);
    tick(20);
    // Write then repeated-START read.
    s_start = n_start;
    tx_bytes = '{8'h10};
    run_txn("rs_wr", 7'h22, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    rd_bytes = '{8'hC7};
    run_txn("rs_rd", 7'h22, 1'b1, 1, 1'b1, 1'b1, 1'b0);
    check_eq("rs/start_total", n_start - s_start, 2);
    tick(20);
    // Late read data.
    rd_delay = 500;
    rd_bytes = '{8'h96};
    run_txn("late", 7'h22, 1'b1, 1, 1'b0, 1'b1, 1'b1);
    tick(600);
    rd_delay = 1;

    // Reset in the middle of a write byte.
    wr_q.delete();
    i2c_start();
    write_byte({7'h22, 1'b0}, ack);
    check_eq("rstmid/addr_ack", ack, 0);
    b = 8'hC3;
    for (int i = 7; i >= 4; i--) put_bit(b[i]);
    rst_i = 1'b1; tick(1);
    check_eq("rstmid/sda_oe", sda_oe, 0);
    check_eq("rstmid/scl_oe", scl_oe, 0);
    check_eq("rstmid/busy", busy_o, 0);
    rst_i = 1'b0;
    for (int i = 3; i >= 0; i--) put_bit(b[i]);
    get_bit(ack);
    check_eq("rstmid/no_ack", ack, 1);
    i2c_stop();
    check_eq("rstmid/no_wr", wr_q.size(), 0);
    // Reset while the address ACK is being driven.
    i2c_start();
    b = {7'h22, 1'b0};
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    sda_m = 1'b1; tick(Q); scl_release(); tick(H/2);
    check_eq("rstack/driving", sda_oe, 1);
    rst_i = 1'b1; tick(1);
    check_eq("rstack/sda_oe", sda_oe, 0);
    rst_i = 1'b0;
    tick(H/2 - 1); scl_m = 1'b0; tick(Q);
    i2c_stop();
    tick(20);
    tx_bytes = '{8'h5A, 8'hE1};
    run_txn("after_rst", 7'h22, 1'b0, 2, 1'b0, 1'b1, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 12; t++) begin
      logic [6:0] a;
      logic rd;
      int n;
      slave_addr = 7'($urandom);
      a = ($urandom_range(0, 3) != 0) ? slave_addr : (slave_addr ^ 7'($urandom_range(1, 127)));
      rd = 1'($urandom);
      n = $urandom_range(1, 3);
      rd_delay = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        tx_bytes.push_back(8'($urandom));
        rd_bytes.push_back(8'($urandom));
      end
      if (!rd) rd_bytes.delete(); else tx_bytes.delete();
      tick(20);
      run_txn("rand", a, rd, n, 1'b0, 1'b1, 1'b0);
    end
    tick(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
